// File: rtl/gmux_switch_seq.sv
// Glitch-free select sequencer for the global clock mux.
// Gates spine quadrants, swaps SSEL, settles, then re-enables in order.
module gmux_switch_seq #(
  parameter int NUM_SRC       = 4,
  parameter int NUM_QUAD      = 4,
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  localparam int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SEL_W-1:0]    REQ_SEL,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [NUM_QUAD-1:0] QUAD_EN,
  input  logic                VLP_REQ,
  output logic [SEL_W-1:0]    SSEL,
  output logic [NUM_QUAD-1:0] DEN,
  output logic                VLP,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int MAXC =
    (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_QUAD-1:0] ONE = NUM_QUAD'(1);

  typedef enum logic [2:0] {
    IDLE, GATE, SETTLE, UNGATE, LP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    ssel_q, ssel_d;
  logic [SEL_W-1:0]    tgt_q, tgt_d;
  logic [NUM_QUAD-1:0] den_q, den_d;
  logic [NUM_QUAD-1:0] ptr_q, ptr_d;
  logic                vlp_q, vlp_d;
  logic                lp_q, lp_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  assign REQ_READY = (state_q == IDLE) & ~VLP_REQ & ~RST;
  assign BUSY      = (state_q != IDLE);
  assign SSEL      = ssel_q;
  assign DEN       = den_q;
  assign VLP       = vlp_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ssel_d  = ssel_q;
    tgt_d   = tgt_q;
    den_d   = den_q;
    ptr_d   = ptr_q;
    vlp_d   = vlp_q;
    lp_d    = lp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        den_d = QUAD_EN;
        if (VLP_REQ) begin
          state_d = GATE;
          lp_d    = 1'b1;
          den_d   = '0;
          cnt_d   = G_LD;
        end else if (REQ_VALID) begin
          if (int'(REQ_SEL) >= NUM_SRC) begin
            err_d = 1'b1;
          end else if (REQ_SEL == ssel_q) begin
            done_d = 1'b1;
          end else begin
            state_d = GATE;
            tgt_d   = REQ_SEL;
            lp_d    = 1'b0;
            den_d   = '0;
            cnt_d   = G_LD;
          end
        end
      end
      GATE: begin
        den_d = '0;
        if (cnt_q == '0) begin
          if (lp_q) begin
            state_d = LP;
            vlp_d   = 1'b1;
          end else begin
            ssel_d  = tgt_q;
            state_d = SETTLE;
            cnt_d   = S_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LP: begin
        den_d = '0;
        if (!VLP_REQ) begin
          vlp_d   = 1'b0;
          lp_d    = 1'b0;
          state_d = SETTLE;
          cnt_d   = S_LD;
        end
      end
      SETTLE: begin
        den_d = '0;
        if (cnt_q == '0) begin
          // The exit edge already enables quadrant 0.
          state_d = UNGATE;
          den_d   = QUAD_EN & ONE;
          ptr_d   = ONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UNGATE: begin
        if (ptr_q[NUM_QUAD-1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q << 1;
          den_d = den_q | (QUAD_EN & (ptr_q << 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ssel_q  <= '0;
      tgt_q   <= '0;
      den_q   <= '0;
      ptr_q   <= '0;
      vlp_q   <= 1'b0;
      lp_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ssel_q  <= ssel_d;
      tgt_q   <= tgt_d;
      den_q   <= den_d;
      ptr_q   <= ptr_d;
      vlp_q   <= vlp_d;
      lp_q    <= lp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gmux_switch_seq.sv
// Directed bench for gmux_switch_seq (NUM_SRC=3 so out-of-range is encodable).
// Cycle n is the interval after the n-th edge counted from the accepting edge 0.
module tb_gmux_switch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_sel;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] quad_en;
  logic       vlp_req;
  logic [1:0] ssel;
  logic [3:0] den;
  logic       vlp, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gmux_switch_seq #(
    .NUM_SRC(3), .NUM_QUAD(4),
    .GATE_CYCLES(4), .SETTLE_CYCLES(8)
  ) dut (
    .CLK(clk), .RST(rst),
    .REQ_SEL(req_sel), .REQ_VALID(req_valid),
    .REQ_READY(req_ready), .QUAD_EN(quad_en),
    .VLP_REQ(vlp_req), .SSEL(ssel), .DEN(den),
    .VLP(vlp), .BUSY(busy), .DONE(done), .ERR(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_sel = '0; req_valid = 1'b0;
    quad_en = 4'b1111; vlp_req = 1'b0;
    step(); step();
    checks++;
    if ({ssel, den, vlp, busy, done, err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0",
               {ssel, den, vlp, busy, done, err});
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", req_ready);
    end
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if (den !== 4'b1111 || ssel !== 2'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_track den %b ssel %0d rdy %b exp 1111 0 1",
               den, ssel, req_ready);
    end
  endtask

  task automatic test_switch();
    logic [3:0] ed;
    req_sel = 2'd2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      ed = (c < 13) ? 4'b0000 : (c == 13) ? 4'b0001 :
           (c == 14) ? 4'b0011 : (c == 15) ? 4'b0111 : 4'b1111;
      checks++;
      if (den !== ed) begin
        errors++;
        $display("FAIL sw_den cyc %0d got %b exp %b", c, den, ed);
      end
      checks++;
      if (ssel !== ((c < 5) ? 2'd0 : 2'd2)) begin
        errors++;
        $display("FAIL sw_ssel cyc %0d got %0d", c, ssel);
      end
      checks++;
      if (done !== (c == 17)) begin
        errors++;
        $display("FAIL sw_done cyc %0d got %b", c, done);
      end
      checks++;
      if (busy !== (c <= 16)) begin
        errors++;
        $display("FAIL sw_busy cyc %0d got %b", c, busy);
      end
      step();
    end
  endtask

  task automatic test_partial();
    req_sel = 2'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 6) quad_en = 4'b1010;
      checks++;
      if (den[0] !== 1'b0 || den[2] !== 1'b0) begin
        errors++;
        $display("FAIL part_den02 cyc %0d got %b exp x0x0", c, den);
      end
      if (c == 14) begin
        checks++;
        if (den !== 4'b0010) begin
          errors++;
          $display("FAIL part_den14 got %b exp 0010", den);
        end
      end
      if (c == 17) begin
        checks++;
        if (den !== 4'b1010 || done !== 1'b1 || ssel !== 2'd1) begin
          errors++;
          $display("FAIL part_end den %b done %b ssel %0d exp 1010 1 1",
                   den, done, ssel);
        end
      end
      step();
    end
  endtask

  task automatic test_trivial_err();
    req_sel = 2'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || den !== 4'b1010) begin
      errors++;
      $display("FAIL triv done %b busy %b den %b exp 1 0 1010",
               done, busy, den);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL triv_after done %b busy %b exp 0 0", done, busy);
    end
    req_sel = 2'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || ssel !== 2'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL oor err %b busy %b ssel %0d done %b exp 1 0 1 0",
               err, busy, ssel, done);
    end
    step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oor_after err %b busy %b exp 0 0", err, busy);
    end
  endtask

  task automatic test_lp_short();
    quad_en = 4'b1111; vlp_req = 1'b1;
    step();
    vlp_req = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 5 || c == 6) begin
        checks++;
        if (vlp !== (c == 5) || busy !== 1'b1) begin
          errors++;
          $display("FAIL lps_vlp cyc %0d vlp %b busy %b", c, vlp, busy);
        end
      end
      checks++;
      if (done !== (c == 18)) begin
        errors++;
        $display("FAIL lps_done cyc %0d got %b", c, done);
      end
      if (c == 18) begin
        checks++;
        if (den !== 4'b1111 || ssel !== 2'd1) begin
          errors++;
          $display("FAIL lps_end den %b ssel %0d exp 1111 1", den, ssel);
        end
      end
      step();
    end
  endtask

  task automatic test_lp_and_reset();
    logic [3:0] ed;
    vlp_req = 1'b1; req_valid = 1'b1; req_sel = 2'd2;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL lp_ready got %b exp 0", req_ready);
    end
    step();
    for (int c = 1; c <= 33; c++) begin
      ed = (c < 29) ? 4'b0000 : (c == 29) ? 4'b0001 :
           (c == 30) ? 4'b0011 : (c == 31) ? 4'b0111 : 4'b1111;
      checks++;
      if (vlp !== (c >= 5 && c <= 20)) begin
        errors++;
        $display("FAIL lp_vlp cyc %0d got %b", c, vlp);
      end
      checks++;
      if (den !== ed || ssel !== 2'd1) begin
        errors++;
        $display("FAIL lp_den cyc %0d den %b ssel %0d exp %b 1",
                 c, den, ssel, ed);
      end
      checks++;
      if (done !== (c == 33) || req_ready !== (c == 33)) begin
        errors++;
        $display("FAIL lp_done cyc %0d done %b rdy %b", c, done, req_ready);
      end
      if (c == 20) vlp_req = 1'b0;
      step();
    end
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (busy !== 1'b1 || ssel !== ((c < 5) ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL pend cyc %0d busy %b ssel %0d", c, busy, ssel);
      end
      if (c == 7) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    checks++;
    if ({ssel, den, vlp, busy, done, err} !== 10'b0) begin
      errors++;
      $display("FAIL midrst got %b exp 0",
               {ssel, den, vlp, busy, done, err});
    end
    for (int c = 9; c <= 30; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ssel !== 2'd0) begin
        errors++;
        $display("FAIL no_resume cyc %0d busy %b done %b ssel %0d",
                 c, busy, done, ssel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_partial();
    test_trivial_err();
    test_lp_short();
    test_lp_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
